hello_scroll_sequencer: RTL and testbench

//  Upstream stage for the HELLO 7-seg character decoders. Generates a scrolling
//  "HELLO" + blanks marquee across NUM_DIGITS displays.

---
 rtl/hello_scroll_sequencer.sv | 115 +++++++++++
 tb/tb_hello_scroll_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hello_scroll_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hello_scroll_sequencer
// Brief    : Scrolling "HELLO" + blanks marquee generator. Emits one 3-bit
//            character code per 7-segment digit (000=H 001=E 010=L 011=L
//            100=O 111=blank), advanced by an internal prescaler tick or by
//            manual single-step pulses, in either direction.
// Revision : 1.0 - initial release
// ============================================================================
module hello_scroll_sequencer #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned BLANKS     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    step_i,
  input  logic                    dir_i,
  input  logic                    restart_i,
  output logic [3*NUM_DIGITS-1:0] codes_o,
  output logic                    wrap_o
);

  // Stream period: five letters followed by the blank gap.
  localparam int unsigned c_PERIOD = 5 + BLANKS;
  localparam int unsigned c_PW     = $clog2(c_PERIOD);
  localparam int unsigned c_DW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned c_SW     = $clog2(c_PERIOD + NUM_DIGITS);

  localparam logic [c_PW-1:0] c_POS_LAST = c_PW'(c_PERIOD - 1);
  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(TICK_DIV - 1);
  localparam logic [c_SW-1:0] c_PERIOD_S = c_SW'(c_PERIOD);

  logic [c_PW-1:0] pos_q, pos_d;
  logic [c_DW-1:0] div_q, div_d;
  logic            wrap_q, wrap_d;
  logic            advance;
  logic [c_PW-1:0] pos_adv;

  // Decide whether this cycle advances: restart dominates, then the
  // prescaler while enabled, then a manual step while paused.
  always_comb begin
    div_d   = div_q;
    advance = 1'b0;
    if (restart_i) begin
      div_d = '0;
    end else if (en_i) begin
      if (div_q == c_DIV_LAST) begin
        div_d   = '0;
        advance = 1'b1;
      end else begin
        div_d = div_q + c_DW'(1);
      end
    end else if (step_i) begin
      advance = 1'b1;
    end
  end

  // Position one step along the stream in the sampled direction, wrapping
  // at either end of the period.
  always_comb begin
    pos_adv = pos_q;
    if (dir_i) begin
      pos_adv = (pos_q == '0) ? c_POS_LAST : pos_q - c_PW'(1);
    end else begin
      pos_adv = (pos_q == c_POS_LAST) ? '0 : pos_q + c_PW'(1);
    end
  end

  // Next position and wrap flag; wrap only marks an advance landing on 0.
  always_comb begin
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (restart_i) begin
      pos_d = '0;
    end else if (advance) begin
      pos_d  = pos_adv;
      wrap_d = (pos_adv == '0);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      div_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      div_q  <= div_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap_o = wrap_q;

  // Per-digit stream lookup. The digit offset is reduced modulo the period
  // at elaboration, so pos + offset < 2P and one conditional subtract
  // finishes the wrap without any divider.
  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
      localparam int unsigned c_OFF = (NUM_DIGITS - 1 - k) % c_PERIOD;
      logic [c_SW-1:0] sum;
      logic [c_SW-1:0] idx;

      assign sum = c_SW'(pos_q) + c_SW'(c_OFF);
      assign idx = (sum >= c_PERIOD_S) ? sum - c_PERIOD_S : sum;
      assign codes_o[3*k +: 3] = (idx < c_SW'(5)) ? idx[2:0] : 3'b111;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hello_scroll_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hello_scroll_sequencer
// Brief    : Self-checking bench for hello_scroll_sequencer (TICK_DIV=4).
//            A behavioural model pushes expected {codes, wrap} per cycle into
//            a scoreboard queue that each scenario pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hello_scroll_sequencer;

  localparam int TICK = 4;
  localparam int P    = 8;
  localparam int ND   = 8;

  logic          clk;
  logic          rst_n;
  logic          en_i;
  logic          step_i;
  logic          dir_i;
  logic          restart_i;
  logic [23:0]   codes_o;
  logic          wrap_o;

  int checks;
  int errors;

  // model state
  int   m_pos;
  int   m_div;
  logic m_wrap;

  logic [24:0] sb[$];
  logic [24:0] exp_v;
  logic [24:0] got_v;

  hello_scroll_sequencer #(
    .TICK_DIV  (TICK),
    .NUM_DIGITS(ND),
    .BLANKS    (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .step_i   (step_i),
    .dir_i    (dir_i),
    .restart_i(restart_i),
    .codes_o  (codes_o),
    .wrap_o   (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] exp_codes(input int p);
    logic [23:0] r;
    logic [31:0] j;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      j = 32'((p + ND - 1 - k) % P);
      r[3*k +: 3] = (j < 5) ? j[2:0] : 3'b111;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    m_div  = 0;
    m_wrap = 1'b0;
    sb.delete();
  endtask

  // Drive one clock cycle of stimulus, step the model and push its expectation.
  task automatic cyc(input logic e, input logic s, input logic d, input logic r);
    logic adv;
    en_i = e; step_i = s; dir_i = d; restart_i = r;
    adv = 1'b0;
    if (r) begin
      m_pos = 0; m_div = 0;
    end else if (e) begin
      if (m_div == TICK - 1) begin m_div = 0; adv = 1'b1; end
      else m_div = m_div + 1;
    end else if (s) begin
      adv = 1'b1;
    end
    m_wrap = 1'b0;
    if (adv) begin
      if (d) m_pos = (m_pos == 0) ? P - 1 : m_pos - 1;
      else   m_pos = (m_pos + 1) % P;
      m_wrap = (m_pos == 0);
    end
    sb.push_back({exp_codes(m_pos), m_wrap});
    @(posedge clk);
    #1;
    en_i = 1'b0; step_i = 1'b0; restart_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_i = 1'b0; step_i = 1'b0; dir_i = 1'b0; restart_i = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({codes_o, wrap_o} !== {24'h0539FF, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got codes=%h wrap=%b want codes=0539ff wrap=0", codes_o, wrap_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL reset_idle got %h want %h", got_v, exp_v);
      end
    end
  endtask

  task automatic test_step();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
    checks++;
    if (got_v !== exp_v || codes_o !== 24'h29CFF8) begin
      errors++;
      $display("FAIL step_left got %h want %h (codes 29cff8)", got_v, exp_v);
    end
    // step ignored while en=1 (div counts instead)
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
    checks++;
    if (got_v !== exp_v || codes_o !== 24'h29CFF8) begin
      errors++;
      $display("FAIL step_with_en got %h want %h", got_v, exp_v);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL step_restart got %h want %h", got_v, exp_v);
    end
  endtask

  task automatic test_step_right();
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
    checks++;
    if (got_v !== exp_v || got_v !== {24'hE0A73F, 1'b0}) begin
      errors++;
      $display("FAIL step_right got %h want %h (codes e0a73f wrap 0)", got_v, exp_v);
    end
    // stepping left from pos 7 lands on 0 and must pulse wrap once
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
    checks++;
    if (got_v !== exp_v || wrap_o !== 1'b1) begin
      errors++;
      $display("FAIL step_wrap got %h want %h", got_v, exp_v);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
    checks++;
    if (got_v !== exp_v || wrap_o !== 1'b0) begin
      errors++;
      $display("FAIL step_wrap_end got %h want %h", got_v, exp_v);
    end
  endtask

  task automatic test_auto();
    int wraps;
    int changes;
    logic [23:0] prev;
    wraps = 0; changes = 0;
    prev = codes_o;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL auto_cycle%0d got %h want %h", i, got_v, exp_v);
      end
      if (wrap_o === 1'b1) wraps++;
      if (codes_o !== prev) changes++;
      prev = codes_o;
    end
    checks++;
    if (wraps != 1 || changes != 8 || {codes_o, wrap_o} !== {24'h0539FF, 1'b1}) begin
      errors++;
      $display("FAIL auto_summary got wraps=%0d changes=%0d codes=%h wrap=%b want 1 8 0539ff 1",
               wraps, changes, codes_o, wrap_o);
    end
  endtask

  task automatic test_restart();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
    // restart with div at TICK-1 and a step: nothing may advance
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
    checks++;
    if (got_v !== exp_v || got_v !== {24'h0539FF, 1'b0}) begin
      errors++;
      $display("FAIL restart_priority got %h want %h", got_v, exp_v);
    end
    // div was cleared: first advance needs a full TICK cycles
    for (int i = 0; i < TICK; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL restart_div_clear%0d got %h want %h", i, got_v, exp_v);
      end
    end
    // asynchronous reset mid-count, checked before any clock edge
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({codes_o, wrap_o} !== {24'h0539FF, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got codes=%h wrap=%b want 0539ff 0", codes_o, wrap_o);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_div_hold();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
      checks++;
      if (exp_v[24:1] !== 24'h0539FF || got_v !== {24'h0539FF, 1'b0}) begin
        errors++;
        $display("FAIL hold_pause%0d got %h want %h", i, got_v, exp_v);
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
    checks++;
    if (got_v !== exp_v || codes_o !== 24'h0539FF) begin
      errors++;
      $display("FAIL hold_resume1 got %h want %h", got_v, exp_v);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
    checks++;
    if (got_v !== exp_v || codes_o !== 24'h29CFF8) begin
      errors++;
      $display("FAIL hold_resume2 got %h want %h", got_v, exp_v);
    end
  endtask

  // Random mix of en/step/dir/restart back to back against the model.
  task automatic test_back_to_back();
    logic e, s, d, r;
    for (int i = 0; i < 150; i++) begin
      e = ($urandom_range(0, 2) == 0);
      s = $urandom_range(0, 1);
      d = $urandom_range(0, 1);
      r = ($urandom_range(0, 19) == 0);
      cyc(e, s, d, r);
      exp_v = sb.pop_front(); got_v = {codes_o, wrap_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL b2b_cycle%0d got %h want %h", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_step();
    test_step_right();
    test_auto();
    test_restart();
    test_div_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
